// File: rtl/seq_frac_divider.sv
// Multi-cycle restoring divider: quotient = floor(dividend * 2^FRAC_W / divisor),
// saturated to QUOT_W bits, one quotient bit per enabled cycle.
//
// state | meaning
// IDLE  | waiting for start (or a pending auto-restart after a divide-by-zero)
// CALC  | shifting out one quotient bit per enabled edge
module seq_frac_divider #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 16,
  parameter int FRAC_W     = 8,
  parameter int QUOT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start,
  input  logic                  auto_restart,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [QUOT_W-1:0]     quotient,
  output logic                  done,
  output logic                  busy,
  output logic                  div_by_zero,
  output logic                  saturated
);

  localparam int NUM_W = DIVIDEND_W + FRAC_W;
  localparam int REM_W = DIVISOR_W + 1;
  localparam int CNT_W = $clog2(NUM_W);

  typedef enum logic [0:0] {IDLE, CALC} state_t;

  state_t             state;
  logic [NUM_W-1:0]   num;
  logic [DIVISOR_W-1:0] den;
  logic [REM_W-1:0]   rem;
  logic [CNT_W-1:0]   cnt;

  logic [REM_W:0]     rem_sh;
  logic [REM_W:0]     den_ext;
  logic               ge;
  logic [NUM_W-1:0]   q_raw;
  logic               sat_nx;
  logic               go;

  // num doubles as the quotient shift register: dividend bits leave at the top
  // while quotient bits enter at the bottom.
  always_comb begin
    rem_sh  = {rem, num[NUM_W-1]};
    den_ext = {2'b00, den};
    ge      = (rem_sh >= den_ext);
    q_raw   = {num[NUM_W-2:0], ge};
    sat_nx  = |q_raw[NUM_W-1:QUOT_W];
    go      = start | (auto_restart & done & div_by_zero);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      num         <= '0;
      den         <= '0;
      rem         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
      saturated   <= 1'b0;
    end else if (en) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            if (divisor == '0) begin
              quotient    <= '1;
              div_by_zero <= 1'b1;
              saturated   <= 1'b0;
              done        <= 1'b1;
            end else begin
              num   <= {dividend, {FRAC_W{1'b0}}};
              den   <= divisor;
              rem   <= '0;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          num <= q_raw;
          rem <= REM_W'(ge ? rem_sh - den_ext : rem_sh);
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(NUM_W - 1)) begin
            quotient    <= sat_nx ? '1 : q_raw[QUOT_W-1:0];
            saturated   <= sat_nx;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            if (auto_restart) begin
              num <= {dividend, {FRAC_W{1'b0}}};
              den <= divisor;
              rem <= '0;
              cnt <= '0;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_frac_divider.sv
// Scoreboard bench for seq_frac_divider: expected results are queued at stimulus
// time and checked by a monitor on each completion pulse.
module tb_seq_frac_divider;

  logic        tb_clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        start = 1'b0;
  logic        auto_restart = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic [7:0]  quotient;
  logic        done, busy, div_by_zero, saturated;

  typedef struct {
    logic [7:0] q;
    logic       sat;
    logic       dbz;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  logic en_edge = 1'b1;

  seq_frac_divider dut (
    .clk(tb_clk), .rst(rst), .en(en), .start(start), .auto_restart(auto_restart),
    .dividend(dividend), .divisor(divisor), .quotient(quotient), .done(done),
    .busy(busy), .div_by_zero(div_by_zero), .saturated(saturated)
  );

  always #5 tb_clk = ~tb_clk;

  always @(posedge tb_clk) en_edge <= en;

  function automatic exp_t model(input logic [15:0] dd, input logic [15:0] dv);
    exp_t   e;
    longint raw;
    if (dv == 16'd0) begin
      e.q = 8'hFF; e.sat = 1'b0; e.dbz = 1'b1;
    end else begin
      raw   = (longint'(dd) * 256) / longint'(dv);
      e.sat = (raw > 255);
      e.q   = e.sat ? 8'hFF : 8'(raw);
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: every fresh done pulse must match the oldest queued expectation.
  always @(negedge tb_clk) begin
    exp_t e;
    if (!rst && done && en_edge) begin
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_done: got done=1 q=%0d, required no completion", quotient);
      end else begin
        e = sb.pop_front();
        if (quotient !== e.q || saturated !== e.sat || div_by_zero !== e.dbz) begin
          tests_failed++;
          $display("FAIL result: got q=%0d sat=%b dbz=%b, required q=%0d sat=%b dbz=%b",
                   quotient, saturated, div_by_zero, e.q, e.sat, e.dbz);
        end
      end
    end
  end

  // Waits for done after the current edge; returns edges elapsed (0 = this edge).
  task automatic wait_done(input int start_lat, output int lat);
    lat = start_lat;
    while (!done && lat < 200) begin
      @(posedge tb_clk);
      lat++;
      #1;
    end
  endtask

  task automatic check_lat(input string name, input int lat, input int exp_lat);
    tests_run++;
    if (lat !== exp_lat) begin
      tests_failed++;
      $display("FAIL %s_latency: got %0d edges, required %0d", name, lat, exp_lat);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp_v);
    tests_run++;
    if (got !== exp_v) begin
      tests_failed++;
      $display("FAIL %s: got %b, required %b", name, got, exp_v);
    end
  endtask

  task automatic accept(input logic [15:0] dd, input logic [15:0] dv, input logic ar);
    @(negedge tb_clk);
    dividend = dd; divisor = dv; start = 1'b1; auto_restart = ar;
    @(posedge tb_clk);
    #1 start = 1'b0;
  endtask

  task automatic run_div(input string name, input logic [15:0] dd, input logic [15:0] dv,
                         input int exp_lat);
    int lat;
    sb.push_back(model(dd, dv));
    accept(dd, dv, 1'b0);
    wait_done(0, lat);
    check_lat(name, lat, exp_lat);
    check_bit({name, "_busy_at_done"}, busy, 1'b0);
    @(negedge tb_clk);
  endtask

  task automatic test_reset;
    @(negedge tb_clk);
    tests_run++;
    if (quotient !== 8'd0 || done !== 1'b0 || busy !== 1'b0 ||
        div_by_zero !== 1'b0 || saturated !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got q=%0d done=%b busy=%b dbz=%b sat=%b, required all 0",
               quotient, done, busy, div_by_zero, saturated);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    run_div("basic_247", 16'd22000, 16'd22727, 24);
  endtask

  task automatic test_reset_mid_calc;
    accept(16'd22000, 16'd22727, 1'b0);
    repeat (10) @(posedge tb_clk);
    #1 rst = 1'b1;
    @(negedge tb_clk);
    tests_run++;
    if (quotient !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_calc: got q=%0d busy=%b done=%b, required 0 0 0",
               quotient, busy, done);
    end
    rst = 1'b0;
    repeat (30) @(negedge tb_clk);
    check_bit("idle_after_reset_busy", busy, 1'b0);
  endtask

  task automatic test_saturation;
    run_div("sat_exact_256", 16'd22727, 16'd22727, 24);
    run_div("zero_dividend", 16'd0, 16'd22727, 24);
    run_div("max_over_one", 16'hFFFF, 16'd1, 24);
    run_div("just_below_sat", 16'd255, 16'd256, 24);
  endtask

  task automatic test_div_by_zero;
    run_div("div_zero", 16'd1234, 16'd0, 0);
    run_div("after_div_zero", 16'd22000, 16'd22727, 24);
  endtask

  task automatic test_auto_restart;
    int lat;
    sb.push_back(model(16'd22000, 16'd22727));
    sb.push_back(model(16'd11000, 16'd22727));
    accept(16'd22000, 16'd22727, 1'b1);
    repeat (10) @(posedge tb_clk);
    #1 dividend = 16'd11000;
    wait_done(10, lat);
    check_lat("auto_first", lat, 24);
    check_bit("auto_busy_held", busy, 1'b1);
    auto_restart = 1'b0;
    @(posedge tb_clk);
    #1;
    wait_done(1, lat);
    check_lat("auto_second", lat, 24);
    check_bit("auto_busy_end", busy, 1'b0);
    @(negedge tb_clk);
  endtask

  task automatic test_back_to_back;
    int lat;
    sb.push_back(model(16'd500, 16'd1000));
    sb.push_back(model(16'd3000, 16'd7));
    accept(16'd500, 16'd1000, 1'b0);
    wait_done(0, lat);
    check_lat("b2b_first", lat, 24);
    dividend = 16'd3000; divisor = 16'd7; start = 1'b1;
    @(posedge tb_clk);
    #1 start = 1'b0;
    wait_done(0, lat);
    check_lat("b2b_second", lat, 24);
    @(negedge tb_clk);
  endtask

  task automatic test_stall;
    int lat;
    sb.push_back(model(16'd22000, 16'd22727));
    accept(16'd22000, 16'd22727, 1'b0);
    lat = 0;
    repeat (5) begin @(posedge tb_clk); lat++; end
    #1 en = 1'b0; dividend = 16'd1; divisor = 16'd1; start = 1'b1;
    repeat (10) begin @(posedge tb_clk); lat++; end
    #1 en = 1'b1;
    repeat (2) begin @(posedge tb_clk); lat++; end
    #1 start = 1'b0;
    wait_done(lat, lat);
    check_lat("stall", lat, 34);
    check_bit("stall_busy_at_done", busy, 1'b0);
    @(negedge tb_clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_mid_calc();
    test_saturation();
    test_div_by_zero();
    test_auto_restart();
    test_back_to_back();
    test_stall();
    repeat (3) @(negedge tb_clk);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d results outstanding, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
